// File: rtl/phase_bank_pkg.sv
// Shared constants, FSM state encoding and the frame range check for the
// ultrasonic phase bank and its byte-stream frame parser.
package phase_bank_pkg;

  localparam logic [7:0] SOF            = 8'hA5;
  localparam logic [7:0] TRAILER_HOLD   = 8'h00;
  localparam logic [7:0] TRAILER_COMMIT = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BASE_HI,
    ST_BASE_LO,
    ST_COUNT,
    ST_DATA,
    ST_TRAILER,
    ST_DISCARD,
    ST_WAIT_SWAP
  } state_e;

  // Sum is formed at 17 bits so a base near 0xFFFF cannot wrap into range.
  function automatic logic range_bad(input logic [15:0] base,
                                     input logic [7:0]  count,
                                     input logic [16:0] limit);
    return (count == 8'd0) || (({1'b0, base} + {9'd0, count}) > limit);
  endfunction

endpackage

// File: rtl/phase_frame_parser.sv
// Byte-stream frame parser: SOF/base/count/data/trailer decoding, range check
// and inter-byte timeout; emits shadow write strobes, commit and error.
module phase_frame_parser
  import phase_bank_pkg::*;
#(
  parameter int NUM_CHANNELS = 256,
  parameter int PHASE_W      = 7,
  parameter int TIMEOUT_CYC  = 1000,
  parameter int IDX_W        = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [7:0]         i_data,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_swap_done,
  output logic               o_wr_en,
  output logic [IDX_W-1:0]   o_wr_idx,
  output logic [PHASE_W-1:0] o_wr_phase,
  output logic               o_wr_enb,
  output logic               o_commit,
  output logic               o_error
);

  localparam int              TO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [16:0]     CH_LIMIT = 17'(NUM_CHANNELS);

  state_e            r_state;
  state_e            w_next;
  logic              r_live;
  logic              r_err;
  logic [7:0]        r_base_hi;
  logic [15:0]       r_idx;
  logic [8:0]        r_rem;
  logic [TO_W-1:0]   r_idle;
  logic              w_acc;
  logic              w_in_frame;
  logic              w_timeout;
  logic              w_range_bad;
  logic              w_err;

  assign w_acc       = i_valid && o_ready;
  assign w_in_frame  = (r_state != ST_IDLE) && (r_state != ST_WAIT_SWAP);
  assign w_timeout   = w_in_frame && !w_acc && (r_idle == TO_LAST);
  assign w_range_bad = range_bad(r_idx, i_data, CH_LIMIT);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    if (w_timeout) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:      if (w_acc && (i_data == SOF)) w_next = ST_BASE_HI;
        ST_BASE_HI:   if (w_acc) w_next = ST_BASE_LO;
        ST_BASE_LO:   if (w_acc) w_next = ST_COUNT;
        ST_COUNT:     if (w_acc) w_next = w_range_bad ? ST_DISCARD : ST_DATA;
        ST_DATA:      if (w_acc && (r_rem == 9'd1)) w_next = ST_TRAILER;
        ST_TRAILER:   if (w_acc) w_next = (i_data == TRAILER_COMMIT) ? ST_WAIT_SWAP : ST_IDLE;
        ST_DISCARD:   if (w_acc && (r_rem == 9'd1)) w_next = ST_IDLE;
        ST_WAIT_SWAP: if (i_swap_done) w_next = ST_IDLE;
        default:      w_next = ST_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    o_ready    = r_live && (r_state != ST_WAIT_SWAP);
    o_wr_en    = (r_state == ST_DATA) && w_acc;
    o_wr_idx   = r_idx[IDX_W-1:0];
    o_wr_phase = i_data[PHASE_W-1:0];
    o_wr_enb   = i_data[7];
    o_commit   = (r_state == ST_TRAILER) && w_acc && (i_data == TRAILER_COMMIT);
    w_err      = w_timeout
              || ((r_state == ST_TRAILER) && w_acc &&
                  (i_data != TRAILER_HOLD) && (i_data != TRAILER_COMMIT))
              || ((r_state == ST_DISCARD) && w_acc && (r_rem == 9'd1));
    o_error    = r_err;
  end

  // Frame bookkeeping: base/index, bytes remaining, idle timer
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_live    <= 1'b0;
      r_err     <= 1'b0;
      r_base_hi <= '0;
      r_idx     <= '0;
      r_rem     <= '0;
      r_idle    <= '0;
    end else begin
      r_live <= 1'b1;
      r_err  <= w_err;
      if (!w_in_frame || w_acc) begin
        r_idle <= '0;
      end else begin
        r_idle <= r_idle + 1'b1;
      end
      if (w_acc) begin
        case (r_state)
          ST_BASE_HI: r_base_hi <= i_data;
          ST_BASE_LO: r_idx     <= {r_base_hi, i_data};
          // A rejected frame still owes COUNT payload bytes plus its trailer.
          ST_COUNT:   r_rem     <= w_range_bad ? ({1'b0, i_data} + 9'd1) : {1'b0, i_data};
          ST_DATA: begin
            r_idx <= r_idx + 16'd1;
            r_rem <= r_rem - 9'd1;
          end
          ST_DISCARD: r_rem     <= r_rem - 9'd1;
          default:    r_rem     <= r_rem;
        endcase
      end
    end
  end

endmodule

// File: rtl/phase_bank.sv
// Double-buffered transducer phase/enable bank: frames fill the shadow bank,
// a commit copies it to the active bank at the PWM period boundary.
module phase_bank
  import phase_bank_pkg::*;
#(
  parameter int NUM_CHANNELS = 256,
  parameter int PHASE_W      = 7,
  parameter int CLK_CNT_MAX  = 99,
  parameter int CLK_CNT_W    = 8,
  parameter int TIMEOUT_CYC  = 1000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [CLK_CNT_W-1:0]            cnt,
  output logic [NUM_CHANNELS*PHASE_W-1:0] phase,
  output logic [NUM_CHANNELS-1:0]         pwm_en,
  output logic                            swap_pulse,
  output logic                            frame_error
);

  localparam int                   IDX_W    = $clog2(NUM_CHANNELS);
  localparam logic [CLK_CNT_W-1:0] CNT_LAST = CLK_CNT_W'(CLK_CNT_MAX);

  logic [PHASE_W-1:0]      r_sh_phase  [NUM_CHANNELS];
  logic [PHASE_W-1:0]      r_act_phase [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] r_sh_en;
  logic [NUM_CHANNELS-1:0] r_act_en;
  logic                    r_armed;
  logic                    w_wr_en;
  logic [IDX_W-1:0]        w_wr_idx;
  logic [PHASE_W-1:0]      w_wr_phase;
  logic                    w_wr_enb;
  logic                    w_commit;
  logic                    w_swap;

  phase_frame_parser #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .PHASE_W      (PHASE_W),
    .TIMEOUT_CYC  (TIMEOUT_CYC),
    .IDX_W        (IDX_W)
  ) u_parser (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_data      (in_data),
    .i_valid     (in_valid),
    .o_ready     (in_ready),
    .i_swap_done (w_swap),
    .o_wr_en     (w_wr_en),
    .o_wr_idx    (w_wr_idx),
    .o_wr_phase  (w_wr_phase),
    .o_wr_enb    (w_wr_enb),
    .o_commit    (w_commit),
    .o_error     (frame_error)
  );

  // Armed from the cycle after the commit, so a commit landing on the last
  // counter value waits a full PWM period.
  assign w_swap     = r_armed && (cnt == CNT_LAST);
  assign swap_pulse = w_swap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_armed <= 1'b0;
    end else if (w_commit) begin
      r_armed <= 1'b1;
    end else if (w_swap) begin
      r_armed <= 1'b0;
    end
  end

  // Shadow bank: written byte by byte as frames arrive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_sh_phase[i] <= '0;
      end
      r_sh_en <= '0;
    end else if (w_wr_en) begin
      r_sh_phase[w_wr_idx] <= w_wr_phase;
      r_sh_en[w_wr_idx]    <= w_wr_enb;
    end
  end

  // Active bank: whole-bank copy only at a swap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_act_phase[i] <= '0;
      end
      r_act_en <= '0;
    end else if (w_swap) begin
      r_act_phase <= r_sh_phase;
      r_act_en    <= r_sh_en;
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_pack
    assign phase[g*PHASE_W +: PHASE_W] = r_act_phase[g];
  end
  assign pwm_en = r_act_en;

endmodule

// File: doc/phase_bank.md
PHASE_BANK -- requirements
Module: phase_bank

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 256, transducer channel count (2..65535).
REQ-002 SHALL have parameter PHASE_W, default 7, phase bits per channel (1..7).
REQ-003 SHALL have parameter CLK_CNT_MAX, default 99, last value of the PWM period counter.
REQ-004 SHALL have parameter CLK_CNT_W, default 8, width of the period counter.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1000, maximum idle cycles between bytes inside a frame.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port in_data, input, 8, byte stream from the receiver.
REQ-009 SHALL have port in_valid, input, 1, marks in_data valid.
REQ-010 SHALL have port in_ready, output, 1; a byte is accepted when in_valid and in_ready are both high.
REQ-011 SHALL have port cnt, input, CLK_CNT_W, the free-running PWM period counter.
REQ-012 SHALL have port phase, output, NUM_CHANNELS x PHASE_W, active phases.
REQ-013 SHALL have port pwm_en, output, NUM_CHANNELS, active per-channel enables.
REQ-014 SHALL have port swap_pulse, output, 1, high for one cycle when the active bank updates.
REQ-015 SHALL have port frame_error, output, 1, high for one cycle per rejected frame.

Function
REQ-016 SHALL parse frames of the form SOF(0xA5), BASE_HI, BASE_LO, COUNT, COUNT data bytes, then TRAILER.
REQ-017 SHALL silently drop any byte in IDLE that is not 0xA5.
REQ-018 SHALL use FSM states IDLE -> BASE_HI -> BASE_LO -> COUNT -> DATA -> TRAILER -> IDLE, plus DISCARD and WAIT_SWAP.
REQ-019 SHALL, on each data byte k, write bit 7 to shadow enable[BASE+k] and bits PHASE_W-1:0 to shadow phase[BASE+k]; unused bits are ignored.
REQ-020 SHALL treat COUNT==0 or BASE+COUNT>NUM_CHANNELS as a range error: enter DISCARD, consume COUNT bytes plus the trailer without writing, then pulse frame_error and return to IDLE.
REQ-021 SHALL compute BASE+COUNT at 17 bits, without wrap-around.
REQ-022 SHALL, on TRAILER 0x00 (hold), keep the shadow writes and return to IDLE without swapping.
REQ-023 SHALL, on TRAILER 0x01 (commit), enter WAIT_SWAP.
REQ-024 SHALL, on any other trailer, pulse frame_error and return to IDLE; shadow writes already made are not rolled back.
REQ-025 SHALL hold in_ready low in WAIT_SWAP and high in all other states.
REQ-026 SHALL, in WAIT_SWAP, copy the whole shadow bank into the active bank on the first cycle with cnt==CLK_CNT_MAX strictly after the commit cycle.
REQ-027 SHALL assert swap_pulse in the same cycle as that copy, with phase and pwm_en updated from the next cycle.
REQ-028 SHALL return to IDLE after the swap.
REQ-029 SHALL, in BASE_HI..TRAILER or DISCARD, abort to IDLE and pulse frame_error after TIMEOUT_CYC consecutive cycles with no accepted byte.
REQ-030 SHALL reload the timeout counter on every accepted byte.
REQ-031 SHALL give an accepted SOF in a non-IDLE state no special meaning; it is treated as ordinary payload.
REQ-032 SHALL keep the active bank unchanged except at a swap.
REQ-033 SHALL let no partial frame ever reach phase or pwm_en.

Reset
REQ-034 SHALL, while rst is high, force FSM=IDLE, in_ready=0, and shadow and active phase/enable all 0, and all counters 0.
REQ-035 SHALL, while rst is high, force swap_pulse=0 and frame_error=0.
REQ-036 SHALL drop in_ready to 0 immediately on rst assertion and return it to 1 on the first clk edge after release.
REQ-037 SHALL, on reset mid-frame or in WAIT_SWAP, discard the pending commit.

Structure
REQ-038 SHALL place SOF, TRAILER_HOLD and TRAILER_COMMIT constants and the FSM state enum in package phase_bank_pkg.
REQ-039 SHALL implement byte parsing, timeout and range check in sub-module phase_frame_parser, which emits write strobe, index, data, commit and error.
REQ-040 SHALL keep the shadow/active register arrays and swap logic in phase_bank itself.

Verification
REQ-041 SHALL cover: A5 00 03 02 85 8A 01, swap at cnt==99 -> phase[3]=5 en[3]=1, phase[4]=10 en[4]=1, one swap_pulse, others 0.
REQ-042 SHALL cover: A5 00 FE 03 ... (254+3>256) -> no shadow writes, frame_error after trailer, next frame parses normally.
REQ-043 SHALL cover: two hold frames (0..127, 128..255) then commit -> all 256 channels update in one swap cycle, no intermediate change.
REQ-044 SHALL cover: commit accepted on the cycle cnt==99 -> swap at the following cnt==99, in_ready low in between and in_valid stalled.
REQ-045 SHALL cover: frame stops after 2 data bytes for 1000 cycles -> frame_error, IDLE, active bank unchanged.
REQ-046 SHALL cover: rst pulse in WAIT_SWAP -> all outputs 0, no swap_pulse at the next cnt==99.
